mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk, in, 1, pipeline clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n, in, 1, reset, asynchronous and active-low.
REQ-003 SHALL have ports: ValidM, in, 1, M-stage holds a real instruction.
REQ-004 SHALL have ports: RegWriteM, MemtoRegM, MemReadM, MemWriteM, SignedM, in, 1 each, M-stage controls.
REQ-005 SHALL have ports: SizeM, in, 2, access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-006 SHALL have ports: ALUOutM, WriteDataM, in, 32, address/result and store data.
REQ-007 SHALL have ports: WriteRegM, in, 5, destination register.
REQ-008 SHALL have ports: DMemReq, DMemWe, out, 1, memory request and write enable.
REQ-009 SHALL have ports: DMemAddr, DMemWData, out, 32; DMemBe, out, 4, byte enables.
REQ-010 SHALL have ports: DMemRData, in, 32; DMemAck, in, 1, one-cycle completion pulse.
REQ-011 SHALL have ports: StallM, out, 1, freeze IF..M; MemErrW, out, 1, access timed out.
REQ-012 SHALL have ports: RegWriteW, MemtoRegW, out, 1; ReadDataW, ALUOutW, out, 32; WriteRegW, out, 5.

Function
REQ-013 SHALL define MemOp = ValidM & (MemReadM | MemWriteM).
REQ-014 SHALL implement FSM with states IDLE and WAIT; reset state IDLE.
REQ-015 SHALL drive DMemReq = MemOp in IDLE and 1 in WAIT; DMemWe = MemWriteM while DMemReq.
REQ-016 SHALL drive DMemAddr = {ALUOutM[31:2],2'b00}.
REQ-017 SHALL generate DMemBe:
- word: 1111
- half: 0011 or 1100 by ALUOutM[1]
- byte: one-hot by ALUOutM[1:0]
REQ-018 SHALL replicate store data: byte on all four lanes, half on both halves, word unchanged.
REQ-019 SHALL complete the access in IDLE when DMemAck=1 in the same cycle as MemOp (zero wait); otherwise go IDLE->WAIT.
REQ-020 SHALL stay in WAIT until DMemAck=1, then return to IDLE in the same edge.
REQ-021 SHALL assert StallM combinationally whenever MemOp=1 and the access does not complete this cycle.
REQ-022 SHALL extract load data from DMemRData by SizeM/ALUOutM[1:0]; SignedM=1 sign-extends, 0 zero-extends; word passes unchanged.
REQ-023 SHALL load W registers on each edge with StallM=0:
- RegWriteW = RegWriteM & ValidM
- other fields copied from M
- ReadDataW = extracted load data, captured only when the access completes
REQ-024 SHALL load a bubble on edges with StallM=1: RegWriteW=0, MemtoRegW=0, MemErrW=0; data fields hold.
REQ-025 SHALL ignore DMemAck when DMemReq=0.
REQ-026 SHALL run an 8-bit wait counter, cleared on entering WAIT and incremented each WAIT cycle.
REQ-027 SHALL, when the counter reaches 255 without ack, force completion:
- StallM=0, next state IDLE
- W loads ReadDataW=0, RegWriteW=0, MemErrW=1 for one cycle
REQ-028 SHALL give DMemAck priority over timeout when both occur in the same cycle (normal completion, MemErrW=0).
REQ-029 SHALL have latency M->W of one edge for non-memory ops and (wait cycles + 1) edges for memory ops.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously clear state to IDLE, counter to 0, and all W outputs and MemErrW to 0.
REQ-031 SHALL keep DMemReq=0 and StallM=0 while rst_n=0, including reset asserted mid-WAIT.
REQ-032 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL pass: ALU op, RegWriteM=1, ALUOutM=0x1234, WriteRegM=5 -> next edge: ALUOutW=0x1234, WriteRegW=5, RegWriteW=1, StallM=0.
REQ-034 SHALL pass: LB signed, ALUOutM=0x103, DMemRData=0x80FF_FFFF, ack 3 cycles later -> StallM=1 for 3 cycles, bubbles in W, then ReadDataW=0xFFFF_FF80.
REQ-035 SHALL pass: SH, ALUOutM=0x202, WriteDataM=0x0000_ABCD, ack same cycle -> DMemBe=1100, DMemWData=0xABCD_ABCD, DMemAddr=0x200, no stall.
REQ-036 SHALL pass: LW, never acked -> StallM high for 256 cycles, then MemErrW=1, RegWriteW=0, ReadDataW=0, state IDLE.
REQ-037 SHALL pass: rst_n low during WAIT -> DMemReq, StallM and RegWriteW low immediately; after release, a new LW with ack completes normally.
REQ-038 SHALL pass: DMemAck pulse with MemOp=0 -> no state change and no W load difference.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory access and M->W pipeline register: drives a req/ack data memory port,
// stalls IF..M while an access is outstanding and forces completion after a timeout.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        SignedM,
  input  logic [1:0]  SizeM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemBe,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck,
  output logic        StallM,
  output logic        MemErrW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        dbgState,
  output logic [7:0]  dbgWaitCnt
);

  // Handshake: DMemReq stays high (with address/data/byte enables stable, since
  // M is frozen by StallM) until a cycle in which DMemAck=1; that cycle completes
  // the access. DMemAck seen while DMemReq=0 carries no meaning and is dropped.

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [7:0] WAIT_LIMIT = 8'hFF;

  state_t      state;
  state_t      nextState;
  logic [7:0]  waitCnt;
  logic        memOp;
  logic        memReq;
  logic        ackSeen;
  logic        timeout;
  logic        stall;
  logic [3:0]  byteEn;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign memOp = ValidM & (MemReadM | MemWriteM);

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      waitCnt <= 8'd0;
    end else begin
      state   <= nextState;
      waitCnt <= (state == S_WAIT && nextState == S_WAIT) ? waitCnt + 8'd1 : 8'd0;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: if (memOp && !ackSeen) nextState = S_WAIT;
      S_WAIT: if (ackSeen || timeout) nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // Outputs: everything is gated by rst_n so a reset mid-access drops the request at once
  always_comb begin
    memReq  = 1'b0;
    ackSeen = 1'b0;
    timeout = 1'b0;
    stall   = 1'b0;
    if (rst_n) begin
      memReq  = (state == S_WAIT) ? 1'b1 : memOp;
      ackSeen = DMemAck & memReq;
      timeout = (state == S_WAIT) & (waitCnt == WAIT_LIMIT) & ~ackSeen;
      stall   = memReq & ~ackSeen & ~timeout;
    end
  end

  assign DMemReq    = memReq;
  assign DMemWe     = memReq & MemWriteM;
  assign StallM     = stall;
  assign DMemAddr   = {ALUOutM[31:2], 2'b00};
  assign DMemBe     = byteEn;
  assign DMemWData  = storeData;
  assign dbgState   = state;
  assign dbgWaitCnt = waitCnt;

  // Byte enables and store lane replication
  always_comb begin
    byteEn    = 4'b1111;
    storeData = WriteDataM;
    case (SizeM)
      SZ_HALF: begin
        byteEn    = ALUOutM[1] ? 4'b1100 : 4'b0011;
        storeData = {2{WriteDataM[15:0]}};
      end
      SZ_BYTE: begin
        case (ALUOutM[1:0])
          2'b00:   byteEn = 4'b0001;
          2'b01:   byteEn = 4'b0010;
          2'b10:   byteEn = 4'b0100;
          default: byteEn = 4'b1000;
        endcase
        storeData = {4{WriteDataM[7:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        storeData = WriteDataM;
      end
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    case (ALUOutM[1:0])
      2'b00:   loadByte = DMemRData[7:0];
      2'b01:   loadByte = DMemRData[15:8];
      2'b10:   loadByte = DMemRData[23:16];
      default: loadByte = DMemRData[31:24];
    endcase
    loadHalf = ALUOutM[1] ? DMemRData[31:16] : DMemRData[15:0];
    case (SizeM)
      SZ_HALF: loadData = {{16{SignedM & loadHalf[15]}}, loadHalf};
      SZ_BYTE: loadData = {{24{SignedM & loadByte[7]}}, loadByte};
      default: loadData = DMemRData;
    endcase
  end

  // W pipeline register: bubbles while stalled, error flag on forced completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      MemErrW   <= 1'b0;
      ReadDataW <= 32'd0;
      ALUOutW   <= 32'd0;
      WriteRegW <= 5'd0;
    end else if (stall) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      MemErrW   <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM & ValidM & ~timeout;
      MemtoRegW <= MemtoRegM;
      MemErrW   <= timeout;
      ALUOutW   <= ALUOutM;
      WriteRegW <= WriteRegM;
      if (ackSeen) begin
        ReadDataW <= loadData;
      end else if (timeout) begin
        ReadDataW <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: single-cycle vector table plus hand sequences
// for wait states, timeout, ack/timeout collision and reset during WAIT.
module tb_mem_wb_stage;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk;
  logic        rst_n;
  logic        ValidM, RegWriteM, MemtoRegM, MemReadM, MemWriteM, SignedM;
  logic [1:0]  SizeM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr, DMemWData;
  logic [3:0]  DMemBe;
  logic [31:0] DMemRData;
  logic        DMemAck;
  logic        StallM, MemErrW, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;
  logic        dbgState;
  logic [7:0]  dbgWaitCnt;

  int checks;
  int failures;
  int stallCnt;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .SignedM(SignedM),
    .SizeM(SizeM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemBe(DMemBe), .DMemRData(DMemRData), .DMemAck(DMemAck),
    .StallM(StallM), .MemErrW(MemErrW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .dbgState(dbgState), .dbgWaitCnt(dbgWaitCnt)
  );

  typedef struct {
    logic        valid, regW, memtoReg, memRead, memWrite, signd;
    logic [1:0]  size;
    logic [31:0] aluOut, wData;
    logic [4:0]  wReg;
    logic [31:0] rData;
    logic        ack;
    logic        expReq, expWe;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWData;
    logic        expStall, expRegWW, expMemtoRegW;
    logic [31:0] expReadDataW;
  } vec_t;

  vec_t vecs[11];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ValidM = F; RegWriteM = F; MemtoRegM = F; MemReadM = F; MemWriteM = F; SignedM = F;
    SizeM = 2'b00; ALUOutM = 32'd0; WriteDataM = 32'd0; WriteRegM = 5'd0;
    DMemRData = 32'd0; DMemAck = F;
  endtask

  task automatic drive_vec(input vec_t v);
    ValidM = v.valid; RegWriteM = v.regW; MemtoRegM = v.memtoReg;
    MemReadM = v.memRead; MemWriteM = v.memWrite; SignedM = v.signd;
    SizeM = v.size; ALUOutM = v.aluOut; WriteDataM = v.wData; WriteRegM = v.wReg;
    DMemRData = v.rData; DMemAck = v.ack;
  endtask

  task automatic drive_load(input logic [1:0] size, input logic signd,
                            input logic [31:0] addr, input logic [4:0] reg_d);
    ValidM = T; RegWriteM = T; MemtoRegM = T; MemReadM = T; MemWriteM = F;
    SignedM = signd; SizeM = size; ALUOutM = addr; WriteDataM = 32'd0;
    WriteRegM = reg_d; DMemAck = F;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    // valid regW m2r rd wr sgn size aluOut wData wReg rData ack | req we addr be wdata stall regWW m2rW readDataW
    vecs[0]  = '{T,T,F,F,F,F, 2'b00, 32'h1234, 32'h0, 5'd5, 32'h0, F,
                 F,F, 32'h1234, 4'hF, 32'h0, F, T,F, 32'h0};
    vecs[1]  = '{T,F,F,F,T,F, 2'b01, 32'h202, 32'h0000ABCD, 5'd0, 32'h0, T,
                 T,T, 32'h200, 4'hC, 32'hABCDABCD, F, F,F, 32'h0};
    vecs[2]  = '{T,T,T,T,F,F, 2'b00, 32'h1000, 32'h11223344, 5'd7, 32'hDEADBEEF, T,
                 T,F, 32'h1000, 4'hF, 32'h11223344, F, T,T, 32'hDEADBEEF};
    vecs[3]  = '{T,T,T,T,F,F, 2'b10, 32'h1001, 32'h11223344, 5'd8, 32'h12345680, T,
                 T,F, 32'h1000, 4'h2, 32'h44444444, F, T,T, 32'h00000056};
    vecs[4]  = '{T,T,T,T,F,T, 2'b01, 32'h1002, 32'h11223344, 5'd9, 32'h80017FFF, T,
                 T,F, 32'h1000, 4'hC, 32'h33443344, F, T,T, 32'hFFFF8001};
    vecs[5]  = '{T,T,T,T,F,T, 2'b01, 32'h1000, 32'h11223344, 5'd10, 32'h80017FFF, T,
                 T,F, 32'h1000, 4'h3, 32'h33443344, F, T,T, 32'h00007FFF};
    vecs[6]  = '{T,T,T,T,F,T, 2'b10, 32'h1000, 32'h11223344, 5'd11, 32'h000000F0, T,
                 T,F, 32'h1000, 4'h1, 32'h44444444, F, T,T, 32'hFFFFFFF0};
    vecs[7]  = '{T,F,F,F,T,T, 2'b10, 32'h2002, 32'h000000A5, 5'd0, 32'h00F00000, T,
                 T,T, 32'h2000, 4'h4, 32'hA5A5A5A5, F, F,F, 32'hFFFFFFF0};
    vecs[8]  = '{T,T,T,T,F,F, 2'b11, 32'h3003, 32'h11223344, 5'd12, 32'hCAFEF00D, T,
                 T,F, 32'h3000, 4'hF, 32'h11223344, F, T,T, 32'hCAFEF00D};
    vecs[9]  = '{F,T,F,T,F,F, 2'b00, 32'h4000, 32'h0, 5'd9, 32'h0, T,
                 F,F, 32'h4000, 4'hF, 32'h0, F, F,F, 32'hCAFEF00D};
    vecs[10] = '{T,T,F,F,F,F, 2'b00, 32'h55, 32'h0, 5'd3, 32'h55555555, T,
                 F,F, 32'h54, 4'hF, 32'h0, F, T,F, 32'hCAFEF00D};

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    #2;
    chk("rst_req",   32'(DMemReq), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_regw",  32'(RegWriteW), 32'd0);
    chk("rst_m2r",   32'(MemtoRegW), 32'd0);
    chk("rst_err",   32'(MemErrW), 32'd0);
    chk("rst_rdata", ReadDataW, 32'd0);
    chk("rst_alu",   ALUOutW, 32'd0);
    chk("rst_wreg",  32'(WriteRegW), 32'd0);
    chk("rst_state", 32'(dbgState), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle table
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      chk($sformatf("v%0d_req", i),   32'(DMemReq), 32'(vecs[i].expReq));
      chk($sformatf("v%0d_we", i),    32'(DMemWe), 32'(vecs[i].expWe));
      chk($sformatf("v%0d_addr", i),  DMemAddr, vecs[i].expAddr);
      chk($sformatf("v%0d_be", i),    32'(DMemBe), 32'(vecs[i].expBe));
      chk($sformatf("v%0d_wdata", i), DMemWData, vecs[i].expWData);
      chk($sformatf("v%0d_stall", i), 32'(StallM), 32'(vecs[i].expStall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_regw", i),  32'(RegWriteW), 32'(vecs[i].expRegWW));
      chk($sformatf("v%0d_m2r", i),   32'(MemtoRegW), 32'(vecs[i].expMemtoRegW));
      chk($sformatf("v%0d_rdata", i), ReadDataW, vecs[i].expReadDataW);
      chk($sformatf("v%0d_alu", i),   ALUOutW, vecs[i].aluOut);
      chk($sformatf("v%0d_wreg", i),  32'(WriteRegW), 32'(vecs[i].wReg));
      chk($sformatf("v%0d_err", i),   32'(MemErrW), 32'd0);
      chk($sformatf("v%0d_state", i), 32'(dbgState), 32'd0);
    end

    // Signed byte load acked after three stall cycles
    @(negedge clk);
    drive_load(2'b10, T, 32'h103, 5'd4);
    DMemRData = 32'h80FFFFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_stall", 32'(StallM), 32'd1);
      chk("lb_req",   32'(DMemReq), 32'd1);
      @(posedge clk);
      #1;
      chk("lb_bubble_regw", 32'(RegWriteW), 32'd0);
      chk("lb_bubble_m2r",  32'(MemtoRegW), 32'd0);
      chk("lb_bubble_hold", ALUOutW, 32'h55);
      chk("lb_state_wait",  32'(dbgState), 32'd1);
      @(negedge clk);
    end
    DMemAck = T;
    #1;
    chk("lb_ack_stall", 32'(StallM), 32'd0);
    @(posedge clk);
    #1;
    chk("lb_rdata", ReadDataW, 32'hFFFFFF80);
    chk("lb_regw",  32'(RegWriteW), 32'd1);
    chk("lb_wreg",  32'(WriteRegW), 32'd4);
    chk("lb_state", 32'(dbgState), 32'd0);

    // Word load never acked: forced completion with error
    @(negedge clk);
    drive_load(2'b00, F, 32'h500, 5'd6);
    stallCnt = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!StallM) break;
      stallCnt++;
      @(negedge clk);
    end
    chk("to_stall_cycles", 32'(stallCnt), 32'd256);
    chk("to_cnt", 32'(dbgWaitCnt), 32'd255);
    @(posedge clk);
    #1;
    chk("to_err",   32'(MemErrW), 32'd1);
    chk("to_regw",  32'(RegWriteW), 32'd0);
    chk("to_rdata", ReadDataW, 32'd0);
    chk("to_state", 32'(dbgState), 32'd0);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    chk("to_err_clear", 32'(MemErrW), 32'd0);

    // Ack arriving in the timeout cycle wins
    @(negedge clk);
    drive_load(2'b00, F, 32'h600, 5'd2);
    stallCnt = 0;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (StallM) stallCnt++;
      @(negedge clk);
    end
    DMemAck = T;
    DMemRData = 32'h00000077;
    #1;
    chk("pri_stall_cycles", 32'(stallCnt), 32'd256);
    chk("pri_cnt",   32'(dbgWaitCnt), 32'd255);
    chk("pri_stall", 32'(StallM), 32'd0);
    @(posedge clk);
    #1;
    chk("pri_err",   32'(MemErrW), 32'd0);
    chk("pri_regw",  32'(RegWriteW), 32'd1);
    chk("pri_rdata", ReadDataW, 32'h00000077);

    // Reset asserted while waiting, then a clean zero-wait load
    @(negedge clk);
    drive_load(2'b00, F, 32'h700, 5'd13);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rw_pre_state", 32'(dbgState), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_req",   32'(DMemReq), 32'd0);
    chk("rw_stall", 32'(StallM), 32'd0);
    chk("rw_regw",  32'(RegWriteW), 32'd0);
    chk("rw_state", 32'(dbgState), 32'd0);
    chk("rw_cnt",   32'(dbgWaitCnt), 32'd0);
    chk("rw_rdata", ReadDataW, 32'd0);
    @(negedge clk);
    chk("rw_req_held", 32'(DMemReq), 32'd0);
    rst_n = 1'b1;
    DMemAck = T;
    DMemRData = 32'h0BADF00D;
    #1;
    chk("rw_new_req",   32'(DMemReq), 32'd1);
    chk("rw_new_stall", 32'(StallM), 32'd0);
    @(posedge clk);
    #1;
    chk("rw_new_rdata", ReadDataW, 32'h0BADF00D);
    chk("rw_new_regw",  32'(RegWriteW), 32'd1);
    chk("rw_new_wreg",  32'(WriteRegW), 32'd13);
    chk("rw_new_state", 32'(dbgState), 32'd0);

    @(negedge clk);
    drive_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
